// File: rtl/datagram_rx_pkg.sv
// Shared constants and types for the datagram receiver: message width,
// derived payload byte count and the receive FSM state encoding.
package datagram_rx_pkg;

   localparam int MESSAGE_SIZE = 16;

   function automatic int bytes_for(input int bits);
      return (bits + 7) / 8;
   endfunction

   localparam int NB = bytes_for(MESSAGE_SIZE);

   typedef enum logic [1:0] {
      IDLE,
      PAYLOAD,
      CHECK
   } state_t;

endpackage

// File: rtl/datagram_rx.sv
// Receives checksummed byte packets from the link and publishes the latest
// good datagram to the display stage on the frame-boundary tick.
module datagram_rx #(
   parameter int MESSAGE_SIZE = datagram_rx_pkg::MESSAGE_SIZE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [7:0]              in_data,
   input  logic                    in_sof,
   output logic                    in_ready,
   input  logic                    frame_tick,
   output logic [MESSAGE_SIZE-1:0] datagram,
   output logic                    datagram_valid,
   output logic [7:0]              err_cnt
);

   import datagram_rx_pkg::*;

   localparam int NBB   = bytes_for(MESSAGE_SIZE);
   localparam int IDX_W = (NBB > 1) ? $clog2(NBB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBB - 1);

   state_t                    state;
   state_t                    state_nxt;
   logic [IDX_W-1:0]          byte_idx;
   logic [IDX_W-1:0]          wr_idx;
   logic [NBB*8-1:0]          payload;
   logic [7:0]                csum;
   logic [MESSAGE_SIZE-1:0]   shadow;
   logic                      pending;
   logic                      ready_gap;
   logic                      xfer;
   logic                      wr_en;
   logic                      first_byte;
   logic                      csum_good;
   logic                      csum_bad;

   assign xfer     = in_valid & in_ready;
   assign in_ready = ~ready_gap;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      wr_en      = 1'b0;
      wr_idx     = byte_idx;
      first_byte = 1'b0;
      csum_good  = 1'b0;
      csum_bad   = 1'b0;
      if (xfer) begin
         if (in_sof) begin
            // A start-of-frame byte always (re)starts a packet from byte 0.
            first_byte = 1'b1;
            wr_en      = 1'b1;
            wr_idx     = '0;
            state_nxt  = (NBB == 1) ? CHECK : PAYLOAD;
         end else begin
            case (state)
               PAYLOAD: begin
                  wr_en = 1'b1;
                  if (byte_idx == LAST_IDX) state_nxt = CHECK;
               end
               CHECK: begin
                  csum_good = (in_data == csum);
                  csum_bad  = (in_data != csum);
                  state_nxt = IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: the assembly buffer and running checksum carry no reset; every
   // byte is rewritten after a start-of-frame before it can be committed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < NBB; k++) begin
            if (wr_idx == IDX_W'(k)) payload[k*8 +: 8] <= in_data;
         end
         csum <= first_byte ? in_data : (csum ^ in_data);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx       <= '0;
         shadow         <= '0;
         pending        <= 1'b0;
         datagram       <= '0;
         datagram_valid <= 1'b0;
         err_cnt        <= 8'd0;
         ready_gap      <= 1'b0;
      end else begin
         ready_gap <= csum_good | csum_bad;
         if (wr_en) byte_idx <= wr_idx + 1'b1;

         // The tick publishes the shadow as it stood before this edge.
         if (frame_tick && pending) begin
            datagram       <= shadow;
            datagram_valid <= 1'b1;
         end

         if (csum_good) begin
            shadow  <= payload[MESSAGE_SIZE-1:0];
            pending <= 1'b1;
         end else if (frame_tick) begin
            pending <= 1'b0;
         end

         if (csum_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule
